// File: rtl/mpmc10_burst_addr_gen.sv
// Strip/burst address sequencer: latches a base and strip count on start, then steps one strip per accepted beat.
// Optional MPMC10_ADDR_WRAP_EN confines the increment to an aligned 2^WRAP_LOG2-byte window.
module mpmc10_burst_addr_gen #(
  parameter int              AW         = 32,
  parameter int              STRIP_LOG2 = 4,
  parameter int              CW         = 6,
  parameter logic [AW-1:0]   RST_ADDR   = AW'(32'h1FFFFFFF),
  parameter int              WRAP_LOG2  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] addr_base,
  input  logic [CW-1:0] num_strips,
  input  logic          rdy,
  output logic          cmd_valid,
  output logic [AW-1:0] addr,
  output logic [CW-1:0] strip_cnt,
  output logic          busy,
  output logic          done
);

`ifdef MPMC10_ADDR_WRAP_EN
  localparam int WIN_LOG2 = WRAP_LOG2;
`else
  // Linear mode: the "window" is the whole address space, WRAP_LOG2 has no effect.
  localparam int WIN_LOG2 = AW + 0 * WRAP_LOG2;
`endif

  localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << STRIP_LOG2;
  localparam logic [AW-1:0] STEP       = AW'(1) << STRIP_LOG2;
  localparam logic [AW-1:0] WIN_MASK   = {AW{1'b1}} >> (AW - WIN_LOG2);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr_nx, addr_inc;
  logic [CW-1:0] cnt_nx, last_idx, last_nx;
  logic          accept;

  assign cmd_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = cmd_valid && rdy;

  // Bits above the window keep the latched value; the low strip bits are already zero.
  assign addr_inc = (addr & ~WIN_MASK) | ((addr + STEP) & WIN_MASK);

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    cnt_nx   = strip_cnt;
    last_nx  = last_idx;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nx  = addr_base & ALIGN_MASK;
          cnt_nx   = '0;
          last_nx  = num_strips;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (strip_cnt == last_idx) begin
            state_nx = DONE;
          end else begin
            addr_nx = addr_inc;
            cnt_nx  = strip_cnt + CW'(1);
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= RST_ADDR;
      strip_cnt <= '0;
      last_idx  <= '0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      strip_cnt <= cnt_nx;
      last_idx  <= last_nx;
    end
  end

endmodule

// File: tb/tb_mpmc10_burst_addr_gen.sv
// Scoreboard bench for mpmc10_burst_addr_gen: stimulus pushes expected strips, a negedge monitor pops on each accept.
module tb_mpmc10_burst_addr_gen;

  localparam int          AW   = 32;
  localparam int          CW   = 6;
  localparam logic [31:0] RSTA = 32'h1FFFFFFF;

  logic          clk = 1'b0;
  logic          rst, start, rdy;
  logic [AW-1:0] addr_base;
  logic [CW-1:0] num_strips;
  logic          cmd_valid, busy, done;
  logic [AW-1:0] addr;
  logic [CW-1:0] strip_cnt;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [31:0] exp_addr_q[$];
  int          exp_cnt_q[$];

  mpmc10_burst_addr_gen #(
    .AW(AW), .STRIP_LOG2(4), .CW(CW), .RST_ADDR(RSTA), .WRAP_LOG2(6)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .addr_base(addr_base),
    .num_strips(num_strips), .rdy(rdy), .cmd_valid(cmd_valid), .addr(addr),
    .strip_cnt(strip_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endfunction

  // Reference: strip i of a sequence from base, computed directly rather than by stepping.
  function automatic logic [31:0] model_addr(logic [31:0] base, int i);
    logic [31:0] a;
    logic [31:0] off;
    a   = base & 32'hFFFF_FFF0;
    off = 32'(i) * 32'd16;
`ifdef MPMC10_ADDR_WRAP_EN
    return (a & ~32'h3F) | ((a + off) & 32'h3F);
`else
    return a + off;
`endif
  endfunction

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (cmd_valid === 1'b1 && rdy === 1'b1 && rst === 1'b0) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_accept", {32'd0, addr}, 64'hDEAD);
      end else begin
        chk("accept_addr", {32'd0, addr}, {32'd0, exp_addr_q.pop_front()});
        chk("accept_cnt", 64'(strip_cnt), 64'(exp_cnt_q.pop_front()));
      end
    end
  end

  // mode 0: rdy always high, 1: rdy low on ISSUE cycles 2..4, 2: random rdy
  task automatic run(input logic [31:0] base, input int n, input int mode,
                     input bit mid_start, input bit done_start);
    int acc = 0;
    int j   = 0;
    int dn0;
    dn0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; addr_base = base; num_strips = CW'(n); rdy = 1'b0;
    for (int i = 0; i <= n; i++) begin
      exp_addr_q.push_back(model_addr(base, i));
      exp_cnt_q.push_back(i);
    end
    @(posedge clk); #1;
    start = 1'b0; addr_base = $urandom; num_strips = CW'($urandom);
    while (acc < n + 1 && j < 200) begin
      j++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(j >= 2 && j <= 4);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      start = mid_start && (j == 2);
      if (mid_start && j == 2) begin
        addr_base = $urandom; num_strips = CW'($urandom);
      end
      @(negedge clk);
      chk("issue_valid", 64'(cmd_valid), 64'd1);
      chk("issue_addr", {32'd0, addr}, {32'd0, model_addr(base, acc)});
      chk("issue_cnt", 64'(strip_cnt), 64'(acc));
      @(posedge clk); #1;
      if (rdy) acc++;
    end
    if (j >= 200) chk("issue_timeout", 64'(acc), 64'(n + 1));
    rdy = 1'b0; start = 1'b0;
    if (done_start) begin
      start = 1'b1; addr_base = 32'h0000_7770; num_strips = 6'd2;
    end
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_valid", 64'(cmd_valid), 64'd0);
    chk("done_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_valid", 64'(cmd_valid), 64'd0);
    chk("done_count", 64'(done_cnt), 64'(dn0 + 1));
    chk("sb_empty", 64'(exp_addr_q.size()), 64'd0);
  endtask

  initial begin
    int dn0;
    rst = 1'b1; start = 1'b1; rdy = 1'b0;
    addr_base = 32'h0000_5550; num_strips = 6'd2;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_addr", {32'd0, addr}, {32'd0, RSTA});
    chk("rst_cnt", 64'(strip_cnt), 64'd0);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("rst_start_ignored", 64'(busy), 64'd0);

    run(32'h0000_1238, 3, 0, 1'b0, 1'b0);
    run(32'h0000_1238, 3, 1, 1'b0, 1'b0);
    run(32'h0000_0080, 0, 0, 1'b0, 1'b0);
    run(32'hFFFF_FFF0, 1, 0, 1'b0, 1'b0);
    run(32'h0000_1030, 3, 0, 1'b0, 1'b0);
    run(32'h0000_1030, 3, 1, 1'b0, 1'b0);
    run(32'h0000_4000, 3, 0, 1'b1, 1'b0);
    run(32'h0000_9990, 2, 0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++)
      run($urandom, $urandom_range(0, 7), 2, 1'b0, 1'b0);

    // Mid-sequence reset after two accepts
    dn0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; addr_base = 32'h0000_2000; num_strips = 6'd5;
    for (int i = 0; i <= 5; i++) begin
      exp_addr_q.push_back(model_addr(32'h0000_2000, i));
      exp_cnt_q.push_back(i);
    end
    @(posedge clk); #1; start = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rdy = 1'b0;
    chk("midrst_remaining", 64'(exp_addr_q.size()), 64'd4);
    exp_addr_q.delete();
    exp_cnt_q.delete();
    @(negedge clk);
    chk("midrst_addr", {32'd0, addr}, {32'd0, RSTA});
    chk("midrst_cnt", 64'(strip_cnt), 64'd0);
    chk("midrst_valid", 64'(cmd_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'(dn0));

    // A normal run must still work after the abort
    run(32'h0000_1238, 3, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d want=finish", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mpmc10_burst_addr_gen.md
Name: mpmc10_burst_addr_gen

Overview:
Parametrised strip/burst address sequencer for the mpmc10 controller. On a start pulse it latches a base address and strip count, then issues one strip address per accepted command beat to the memory application interface, with a valid/ready handshake. When the last strip is accepted it signals completion. It replaces the fixed-width, state-decoded address generator and owns its own sequencing state machine.

Parameters:
AW, 32, address width in bits.
STRIP_LOG2, 4, log2 of strip size in bytes; the address increments at bit STRIP_LOG2.
CW, 6, width of the strip count and strip index.
RST_ADDR, 32'h1FFFFFFF, reset value of addr, truncated to AW bits.
WRAP_LOG2, 8, log2 of the wrap window in bytes; used only with MPMC10_ADDR_WRAP_EN; must satisfy STRIP_LOG2 < WRAP_LOG2 <= AW.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  begin a sequence; sampled only in IDLE.
addr_base  input  AW  starting byte address; bits [STRIP_LOG2-1:0] are forced to 0 when latched.
num_strips  input  CW  index of the last strip; the sequence issues num_strips+1 strips.
rdy  input  1  the application interface accepts the current command.
cmd_valid  output  1  addr is valid and presented for acceptance.
addr  output  AW  current strip address.
strip_cnt  output  CW  index of the strip currently presented.
busy  output  1  high in ISSUE and DONE.
done  output  1  one-cycle pulse after the last strip is accepted.

Behaviour:
- Reset values: addr=RST_ADDR, strip_cnt=0, cmd_valid=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-sequence aborts the sequence on the next edge and restores all reset values. No done pulse is produced.
- States: IDLE, ISSUE, DONE; register-encoded.
- IDLE:
  - With start=1: latch addr={addr_base[AW-1:STRIP_LOG2], STRIP_LOG2'b0}, latch num_strips internally, set strip_cnt=0, go to ISSUE.
  - cmd_valid rises on the cycle after start.
- ISSUE:
  - cmd_valid=1.
  - An accept is cmd_valid&&rdy in the same cycle.
  - On an accept with strip_cnt != latched num_strips: addr[AW-1:STRIP_LOG2] += 1 and strip_cnt += 1, both visible next cycle.
  - On an accept with strip_cnt == latched num_strips: addr and strip_cnt hold, go to DONE.
  - With rdy=0: addr, strip_cnt and cmd_valid hold; there is no timeout.
- DONE: cmd_valid=0, done=1 for exactly one cycle, then go to IDLE.
- Latency: first address is presented 1 cycle after start. With rdy held high, N+1 strips take N+1 cycles, and done follows 1 cycle after the last accept.
- Address wrap-around without the optional feature: the increment is modulo 2^(AW-STRIP_LOG2). Example: the top strip rolls to 0 and the low STRIP_LOG2 bits stay 0.
- start while busy: ignored; the latched base and count are unaffected.
- start asserted during the DONE cycle: ignored. A new sequence needs start in IDLE, so back-to-back sequences have a minimum gap of 1 idle cycle.
- Input changes after latch: num_strips and addr_base changes do not affect a running sequence.
- num_strips=0: exactly one strip is issued.
- Width rule: strip_cnt never exceeds the latched num_strips, so there is no CW overflow.

Optional Feature:
MPMC10_ADDR_WRAP_EN.
- Defined: the increment applies only to addr[WRAP_LOG2-1:STRIP_LOG2] modulo 2^(WRAP_LOG2-STRIP_LOG2). addr[AW-1:WRAP_LOG2] holds the latched value for the whole sequence. This gives a burst that wraps inside an aligned 2^WRAP_LOG2-byte window, used for cache-line wrap fills.
- Not defined: linear increment across the full address, as above. WRAP_LOG2 is unused.

Test Plan:
1. Reset, then idle: rst=1 for 2 cycles -> addr=32'h1FFFFFFF, cmd_valid=0, busy=0, done=0. Apply start with rst=1 -> no sequence starts.
2. Basic run: addr_base=32'h0000_1238, num_strips=3, rdy=1 -> cmd_valid for 4 cycles with addr 0x1230, 0x1240, 0x1250, 0x1260 and strip_cnt 0..3. done pulses 1 cycle after the 0x1260 accept; busy falls with the return to IDLE.
3. Backpressure: same as test 2 with rdy low on cycles 2–4 of ISSUE -> addr holds 0x1240 and strip_cnt holds 1 while rdy=0. The full 4-address sequence is unchanged; done arrives 3 cycles later than in test 2.
4. Boundary cases:
   - num_strips=0, base 0x80 -> exactly one accept at 0x80, then done.
   - base 32'hFFFF_FFF0, num_strips=1, linear -> addresses 0xFFFFFFF0 then 0x00000000.
5. Ignored start and mid-run reset:
   - Pulse start with a new base during ISSUE -> sequence unaffected.
   - Assert rst after 2 accepts -> next cycle state=IDLE, addr=RST_ADDR, no done pulse.
6. With MPMC10_ADDR_WRAP_EN and WRAP_LOG2=6: base 0x1030, num_strips=3 -> addresses 0x1030, 0x1000, 0x1010, 0x1020. Without the macro the same stimulus gives 0x1030, 0x1040, 0x1050, 0x1060.
